vga_timing: RTL and testbench

Raster timing generator for the 480x272 RGB565 panel: produces pixel coordinates for the sprite stage and the panel's sync/data-enable strobes. Sits directly upstream of the sprite selector. Its `o_x`/`o_y` feed the sprite selector's coordinate inputs. Its sync and DE outputs are delayed to line up with the sprite selector's 1-cycle ROM read latency, so sync, DE and colour reach the panel on the same clock edge.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_delay_line.sv | 49 ++++
 rtl/vga_timing.sv | 138 +++++++++++++
 tb/tb_vga_timing.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared raster constants for the 480x272 RGB565 panel. This package is the
//   single source of the timing defaults and derived totals, so the timing
//   generator and the sprite selector's active-window bounds cannot drift apart.
//   Contents:
//     - default porch/sync/active values (pixels for H, lines for V)
//     - counter and coordinate widths
//     - strobe_t: the {hsync, vsync, de} bundle carried through the delay line
//     - line_total(): sum of the four segments of a line or frame
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;

    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;

    localparam int CNT_W   = 10;  // raster counter width
    localparam int COORD_W = 9;   // coordinate output width

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } strobe_t;

    // Segment order is active, front porch, sync, back porch.
    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_delay_line.sv
// ---------------------------------------------------------------------------
// delay_line
//   Asynchronous-reset shift register that delays a WIDTH-bit bundle by DEPTH
//   clocks. DEPTH = 0 is a pure wire (no registers). Every stage resets to
//   RST_VAL so the delayed outputs come out of reset at their idle levels.
//   Ports:
//     clk    in  1      clock
//     rst_n  in  1      asynchronous active-low reset
//     d      in  WIDTH  bundle to delay
//     q      out WIDTH  bundle delayed by DEPTH clocks
// ---------------------------------------------------------------------------
module delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Clock and reset are intentionally unused in the bypass case.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Raster timing generator for the 480x272 panel. Free-running horizontal and
//   vertical counters are decoded into coordinates, a frame-start pulse and the
//   panel strobes. Coordinates and o_frame leave after one register stage; the
//   strobes pass through an extra PIPE_DLY-deep delay line so they reach the
//   panel together with the colour coming out of the sprite selector's ROM.
//   Ports:
//     i_clk    in  1  pixel clock, one clock per pixel
//     i_rst_n  in  1  asynchronous active-low reset
//     o_x      out 9  horizontal coordinate (0 outside the active line)
//     o_y      out 9  vertical coordinate (0 outside the active frame)
//     o_hsync  out 1  horizontal sync, level SYNC_POL when active, delayed
//     o_vsync  out 1  vertical sync, level SYNC_POL when active, delayed
//     o_de     out 1  data enable, delayed
//     o_frame  out 1  one-clock pulse at pixel (0,0), undelayed
// ---------------------------------------------------------------------------
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic               o_frame
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam strobe_t STROBE_IDLE = '{hsync: !SYNC_POL, vsync: !SYNC_POL, de: 1'b0};

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;

    logic [COORD_W-1:0] x_p0;
    logic [COORD_W-1:0] y_p0;
    logic               frame_p0;
    strobe_t            strobe_p0;

    logic [COORD_W-1:0] x_p1;
    logic [COORD_W-1:0] y_p1;
    logic               frame_p1;
    strobe_t            strobe_p1;

    strobe_t            strobe_dly;

    // Raster counters: v_cnt advances only on the h_cnt wrap, so both wrap
    // together on the last pixel of the frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // ---- stage p0: decode of the current counter position ----
    always_comb begin
        x_p0            = '0;
        y_p0            = '0;
        frame_p0        = 1'b0;
        strobe_p0       = STROBE_IDLE;

        if (h_cnt < H_ACT_END) x_p0 = h_cnt[COORD_W-1:0];
        if (v_cnt < V_ACT_END) y_p0 = v_cnt[COORD_W-1:0];

        frame_p0        = (h_cnt == '0) && (v_cnt == '0);
        strobe_p0.de    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);

        // vsync decodes v_cnt only, which changes on the h_cnt wrap, so its
        // edges are line-aligned without any extra qualification.
        if ((h_cnt >= HS_START) && (h_cnt < HS_END)) strobe_p0.hsync = SYNC_POL;
        if ((v_cnt >= VS_START) && (v_cnt < VS_END)) strobe_p0.vsync = SYNC_POL;
    end

    // ---- stage p1: output registers ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_p1      <= '0;
            y_p1      <= '0;
            frame_p1  <= 1'b0;
            strobe_p1 <= STROBE_IDLE;
        end else begin
            x_p1      <= x_p0;
            y_p1      <= y_p0;
            frame_p1  <= frame_p0;
            strobe_p1 <= strobe_p0;
        end
    end

    // ---- strobe delay: aligns sync/DE with the sprite ROM read ----
    delay_line #(
        .WIDTH   ($bits(strobe_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (STROBE_IDLE)
    ) u_strobe_dly (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (strobe_p1),
        .q     (strobe_dly)
    );

    assign o_x     = x_p1;
    assign o_y     = y_p1;
    assign o_frame = frame_p1;
    assign o_hsync = strobe_dly.hsync;
    assign o_vsync = strobe_dly.vsync;
    assign o_de    = strobe_dly.de;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//   Four timing generators share one clock and reset:
//     A: small raster (30 x 10), PIPE_DLY = 1, SYNC_POL = 0
//     B: small raster,            PIPE_DLY = 0, SYNC_POL = 1
//     C: small raster,            PIPE_DLY = 3, SYNC_POL = 1
//     D: panel defaults (525 x 286)
//   The reference model maps "clock edges since reset release" to a raster
//   position with plain modular arithmetic and derives every output from it.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    localparam int S_HA = 20, S_HFP = 2, S_HS = 5, S_HBP = 3;   // line = 30
    localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;   // frame = 10 lines

    logic clk = 1'b0;
    logic rst_n;
    logic chk_on = 1'b0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    longint n;  // rising edges since reset release

    logic [8:0] x_a, y_a, x_b, y_b, x_c, y_c, x_d, y_d;
    logic hs_a, vs_a, de_a, fr_a;
    logic hs_b, vs_b, de_b, fr_b;
    logic hs_c, vs_c, de_c, fr_c;
    logic hs_d, vs_d, de_d, fr_d;

    always #5 clk = ~clk;

    vga_timing #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                 .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                 .SYNC_POL(1'b0), .PIPE_DLY(1))
    dut_a (.i_clk(clk), .i_rst_n(rst_n), .o_x(x_a), .o_y(y_a), .o_hsync(hs_a),
           .o_vsync(vs_a), .o_de(de_a), .o_frame(fr_a));

    vga_timing #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                 .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                 .SYNC_POL(1'b1), .PIPE_DLY(0))
    dut_b (.i_clk(clk), .i_rst_n(rst_n), .o_x(x_b), .o_y(y_b), .o_hsync(hs_b),
           .o_vsync(vs_b), .o_de(de_b), .o_frame(fr_b));

    vga_timing #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                 .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                 .SYNC_POL(1'b1), .PIPE_DLY(3))
    dut_c (.i_clk(clk), .i_rst_n(rst_n), .o_x(x_c), .o_y(y_c), .o_hsync(hs_c),
           .o_vsync(vs_c), .o_de(de_c), .o_frame(fr_c));

    vga_timing dut_d (.i_clk(clk), .i_rst_n(rst_n), .o_x(x_d), .o_y(y_d), .o_hsync(hs_d),
                      .o_vsync(vs_d), .o_de(de_d), .o_frame(fr_d));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // Expected {x, y, hsync, vsync, de, frame} after n edges since release.
    // Edge k registers the decode of raster position k-1; strobes additionally
    // lag by d clocks.
    function automatic logic [22:0] model(input longint cnt,
                                          input int ha, input int hfp, input int hsw, input int hbp,
                                          input int va, input int vfp, input int vsw, input int vbp,
                                          input int d, input bit pol);
        int ht, vt, h, v;
        longint p, q;
        logic [8:0] x, y;
        logic hs, vs, de, fr;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        x = '0; y = '0; fr = 1'b0; hs = !pol; vs = !pol; de = 1'b0;
        p = cnt - 1;
        if (p >= 0) begin
            h = int'(p % ht);
            v = int'((p / ht) % vt);
            if (h < ha) x = 9'(h);
            if (v < va) y = 9'(v);
            fr = (h == 0) && (v == 0);
        end
        q = cnt - 1 - d;
        if (q >= 0) begin
            h = int'(q % ht);
            v = int'((q / ht) % vt);
            hs = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : !pol;
            vs = (v >= va + vfp && v < va + vfp + vsw) ? pol : !pol;
            de = (h < ha) && (v < va);
        end
        return {x, y, hs, vs, de, fr};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at n=%0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cycle_A", longint'({x_a, y_a, hs_a, vs_a, de_a, fr_a}),
                  longint'(model(n, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1, 1'b0)));
            check("cycle_B", longint'({x_b, y_b, hs_b, vs_b, de_b, fr_b}),
                  longint'(model(n, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 0, 1'b1)));
            check("cycle_C", longint'({x_c, y_c, hs_c, vs_c, de_c, fr_c}),
                  longint'(model(n, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 3, 1'b1)));
            check("cycle_D", longint'({x_d, y_d, hs_d, vs_d, de_d, fr_d}),
                  longint'(model(n, 480, 2, 41, 2, 272, 2, 10, 2, 1, 1'b0)));
        end
    end

    initial begin
        longint fr_n[$];
        longint hs_fall[$];
        longint first_hs_c, first_hs_d;
        int de_cnt, vs_cnt, hs_run;
        logic hs_prev;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("rst_A_outputs", longint'({x_a, y_a, hs_a, vs_a, de_a, fr_a}), longint'({9'd0, 9'd0, 4'b1100}));
        check("rst_B_sync_level", longint'({hs_b, vs_b}), 0);
        check("rst_C_de", longint'(de_c), 0);

        @(negedge clk);
        rst_n = 1'b1;

        de_cnt = 0; vs_cnt = 0; hs_run = 0; hs_prev = 1'b1;
        first_hs_c = -1; first_hs_d = -1;
        for (int k = 1; k <= 650; k++) begin
            @(negedge clk);
            if (n == 1) begin
                check("first_frame_A", longint'(fr_a), 1);
                check("first_x_A", longint'(x_a), 0);
                check("first_de_A_lags", longint'(de_a), 0);
                check("first_de_B_nolag", longint'(de_b), 1);
                check("first_frame_D", longint'(fr_d), 1);
            end
            if (n == 2) begin
                check("second_de_A", longint'(de_a), 1);
                check("second_x_A", longint'(x_a), 1);
                check("second_frame_A", longint'(fr_a), 0);
            end
            if (n == 480) check("last_x_D", longint'(x_d), 479);
            if (n == 481) check("blank_x_D", longint'(x_d), 0);
            if (fr_a) fr_n.push_back(n);
            if (n <= 300) begin
                if (de_a) de_cnt++;
                if (!vs_a) vs_cnt++;
            end
            if (n <= 30 && !hs_a) hs_run++;
            if (hs_prev && !hs_a) hs_fall.push_back(n);
            hs_prev = hs_a;
            if (first_hs_c < 0 && hs_c) first_hs_c = n;
            if (first_hs_d < 0 && !hs_d) first_hs_d = n;
        end

        check("de_per_frame_A", de_cnt, 120);
        check("vsync_clocks_A", vs_cnt, 60);
        check("hsync_width_A", hs_run, 5);
        check("hsync_first_A", (hs_fall.size() > 0) ? hs_fall[0] : -1, 24);
        check("line_period_A", (hs_fall.size() > 1) ? hs_fall[1] - hs_fall[0] : -1, 30);
        check("hsync_first_C", first_hs_c, 26);
        check("hsync_first_D", first_hs_d, 484);
        check("frame_count_A", fr_n.size(), 3);
        check("frame_period_A", (fr_n.size() > 1) ? fr_n[1] - fr_n[0] : -1, 300);

        // Mid-frame asynchronous reset, asserted between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_A", longint'({x_a, y_a, hs_a, vs_a, de_a, fr_a}), longint'({9'd0, 9'd0, 4'b1100}));
        check("async_rst_C_sync", longint'({hs_c, vs_c, de_c}), 0);
        check("async_rst_D_sync", longint'({hs_d, vs_d}), 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        fr_n.delete();
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            if (n == 1) check("restart_x_y_A", longint'({x_a, y_a}), 0);
            if (fr_a) fr_n.push_back(n);
        end
        check("restart_frame_A", (fr_n.size() > 0) ? fr_n[0] : -1, 1);
        check("restart_period_A", (fr_n.size() > 1) ? fr_n[1] - fr_n[0] : -1, 300);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
